// File: rtl/image_streamer_pkg.sv
// Shared constants, FSM state type and base-address helper for the image
// streamer that feeds the first matrix-multiply layer.
package image_streamer_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int IMG_PIXELS = 784;
  localparam int NUM_IMAGES = 5;
  localparam int IDX_W      = 10;
  localparam int SEL_W      = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  // Images sit back to back; the largest base plus offset (3919) fits ADDR_W.
  function automatic logic [ADDR_W-1:0] base_addr(input logic [SEL_W-1:0] sel);
    return ADDR_W'(sel) * ADDR_W'(IMG_PIXELS);
  endfunction

endpackage

// File: rtl/image_streamer.sv
// Walks the pixel words of one image out of a combinational-read memory and
// presents them on a valid/ready stream. Optional IMAGE_STREAMER_CHECKSUM_EN
// adds a wrapping sum of every handshaken word.
module image_streamer
  import image_streamer_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [SEL_W-1:0]         img_sel,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [DATA_W-1:0] mem_data,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef IMAGE_STREAMER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]        checksum
`endif
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count;
  logic             load;
  logic             accept;
  logic             reject;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    load    = !out_valid || out_ready;
    unique case (state_q)
      IDLE: begin
        // The done cycle still belongs to the previous run, so starts wait.
        if (start && !done) begin
          if (img_sel < SEL_W'(NUM_IMAGES)) begin
            accept  = 1'b1;
            state_d = STREAM;
          end else begin
            reject = 1'b1;
          end
        end
      end
      STREAM:  if (load && count == LAST_IDX) state_d = DRAIN;
      DRAIN:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      count     <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= reject;

      if (accept) begin
        mem_addr <= base_addr(img_sel);
        count    <= '0;
        busy     <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end

      unique case (state_q)
        STREAM: begin
          if (load) begin
            out_data  <= mem_data;
            out_index <= count;
            out_last  <= (count == LAST_IDX);
            out_valid <= 1'b1;
            // The address parks on the final word once it has been loaded.
            if (count != LAST_IDX) begin
              mem_addr <= mem_addr + 1'b1;
              count    <= count + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMAGE_STREAMER_CHECKSUM_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     checksum <= '0;
    else if (accept)                 checksum <= '0;
    else if (out_valid && out_ready) checksum <= checksum + out_data;
  end
`endif

endmodule

// File: tb/tb_image_streamer.sv
// Self-checking bench for image_streamer: a word-level stream model checks
// every valid cycle, with literal cycle/address expectations pinning it.
module tb_image_streamer;
  import image_streamer_pkg::*;

  localparam int MEM_WORDS = NUM_IMAGES * IMG_PIXELS;

  logic                     clk = 1'b0;
  logic                     resetn = 1'b0;
  logic                     start = 1'b0;
  logic [SEL_W-1:0]         img_sel = '0;
  logic                     busy, done, err;
  logic [ADDR_W-1:0]        mem_addr;
  logic signed [DATA_W-1:0] mem_data;
  logic signed [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]         out_index;
  logic                     out_last, out_valid;
  logic                     out_ready = 1'b0;
`ifdef IMAGE_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0]        checksum;
`endif

  image_streamer dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .img_sel   (img_sel),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef IMAGE_STREAMER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Image 0 holds word i = i; other images hold mixed-sign patterns.
  function automatic logic signed [DATA_W-1:0] mem_word(input int a);
    if (a < IMG_PIXELS) return DATA_W'(a);
    if (a % 2 == 1)     return -DATA_W'(a * 13);
    return DATA_W'(a * 1000 + 7);
  endfunction

  logic signed [DATA_W-1:0] mem [MEM_WORDS];
  initial for (int a = 0; a < MEM_WORDS; a++) mem[a] = mem_word(a);
  assign mem_data = (int'(mem_addr) < MEM_WORDS) ? mem[mem_addr] : '0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  // Stream model: which image is expected and how many words have been taken.
  int cyc = 0;
  int t0 = 0;
  int exp_sel = 0;
  int exp_k = 0;
  int done_count = 0;
  int first_valid_cyc = -1;
  int last_cyc = -1;
  int done_cyc = -1;
  logic [DATA_W-1:0] exp_sum = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc - t0;
        if (exp_k >= IMG_PIXELS) begin
          check("extra_word", 64'(exp_k), 64'(IMG_PIXELS - 1));
        end else begin
          check("out_data", 64'(out_data), 64'(mem_word(exp_sel * IMG_PIXELS + exp_k)));
          check("out_index", 64'(out_index), 64'(exp_k));
          check("out_last", 64'(out_last), 64'(exp_k == IMG_PIXELS - 1));
        end
        if (out_ready) begin
          if (out_last && last_cyc < 0) last_cyc = cyc - t0;
          exp_sum = exp_sum + DATA_W'(mem_word(exp_sel * IMG_PIXELS + exp_k));
          exp_k++;
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc - t0;
        check("done_after_all_words", 64'(exp_k), 64'(IMG_PIXELS));
`ifdef IMAGE_STREAMER_CHECKSUM_EN
        check("checksum_model", 64'(checksum), 64'(exp_sum));
`endif
      end
    end
  end

  task automatic pulse_start(input int sel);
    start   = 1'b1;
    img_sel = SEL_W'(sel);
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic start_img(input int sel);
    exp_sel         = sel;
    exp_k           = 0;
    exp_sum         = '0;
    done_count      = 0;
    first_valid_cyc = -1;
    last_cyc        = -1;
    done_cyc        = -1;
    t0              = cyc;
    pulse_start(sel);
  endtask

  task automatic wait_done(input int budget, input bit rand_ready, input string name);
    int n0 = done_count;
    int i = 0;
    while (done_count == n0 && i < budget) begin
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      i++;
    end
    if (done_count == n0) fail_now(name);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    check("reset_mem_addr", 64'(mem_addr), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_data", 64'(out_data), 64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    // Image 0, ready held high: exact cycle timing.
    out_ready = 1'b1;
    start_img(0);
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_mem_addr", 64'(mem_addr), 64'(0));
    check("t1_out_valid", 64'(out_valid), 64'(0));
    wait_done(900, 1'b0, "img0_done");
    check("img0_first_valid_cycle", 64'(first_valid_cyc), 64'(2));
    check("img0_last_cycle", 64'(last_cyc), 64'(785));
    check("img0_done_cycle", 64'(done_cyc), 64'(786));
    check("img0_busy_low", 64'(busy), 64'(0));
    check("img0_out_valid_low", 64'(out_valid), 64'(0));
`ifdef IMAGE_STREAMER_CHECKSUM_EN
    check("img0_checksum", 64'(checksum), 64'(306936));
`endif

    // Image 4: address range 3136..3919.
    start_img(4);
    check("img4_first_addr", 64'(mem_addr), 64'(3136));
    wait_done(900, 1'b0, "img4_done");
    check("img4_last_addr", 64'(mem_addr), 64'(3919));
    check("img4_done_cycle", 64'(done_cyc), 64'(786));

    // Image 2 with pseudo-random back-pressure.
    start_img(2);
    wait_done(5000, 1'b1, "img2_random_done");
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("img2_done_once", 64'(done_count), 64'(1));
    check("img2_word_count", 64'(exp_k), 64'(IMG_PIXELS));

    // Invalid image number.
    pulse_start(5);
    check("err_pulse", 64'(err), 64'(1));
    check("err_busy", 64'(busy), 64'(0));
    check("err_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("err_cleared", 64'(err), 64'(0));
    check("err_valid_later", 64'(out_valid), 64'(0));

    // Start during busy, while stalled, must not move the address.
    out_ready = 1'b0;
    start_img(0);
    repeat (2) @(posedge clk);
    #1;
    check("stall_addr", 64'(mem_addr), 64'(1));
    pulse_start(2);
    check("busy_start_addr", 64'(mem_addr), 64'(1));
    check("busy_start_busy", 64'(busy), 64'(1));
    out_ready = 1'b1;
    wait_done(900, 1'b0, "busy_start_done");
    check("busy_start_last_addr", 64'(mem_addr), 64'(IMG_PIXELS - 1));

    // Reset in the middle of image 3.
    start_img(3);
    begin
      int i = 0;
      while (exp_k < 400 && i < 1000) begin
        @(posedge clk); #1;
        i++;
      end
      if (exp_k < 400) fail_now("reach_word_400");
    end
    resetn = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_mem_addr", 64'(mem_addr), 64'(0));
    check("abort_out_data", 64'(out_data), 64'(0));
    check("abort_out_index", 64'(out_index), 64'(0));
    check("abort_out_last", 64'(out_last), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_count), 64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;
    start_img(1);
    check("restart_addr", 64'(mem_addr), 64'(784));
    wait_done(900, 1'b0, "restart_done");
    check("restart_first_valid_cycle", 64'(first_valid_cyc), 64'(2));
    check("restart_done_cycle", 64'(done_cyc), 64'(786));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
